// File: rtl/sobel_mag_sq_pkg.sv
// Shared edge-detect constants: pixel/radicand/sqrt widths, derived gradient
// and square widths, and the 3x3 window pixel indices (row-major).
package sobel_mag_sq_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned RAD_W  = 23;
    localparam int unsigned SQRT_W = 11;
    localparam int unsigned GRAD_W = PIX_W + 3;
    localparam int unsigned SQ_W   = 2 * (PIX_W + 2);

    // Window layout: row 0 = P0 P1 P2, row 1 = P3 P4 P5, row 2 = P6 P7 P8
    localparam int unsigned P0 = 0;
    localparam int unsigned P1 = 1;
    localparam int unsigned P2 = 2;
    localparam int unsigned P3 = 3;
    localparam int unsigned P4 = 4;
    localparam int unsigned P5 = 5;
    localparam int unsigned P6 = 6;
    localparam int unsigned P7 = 7;
    localparam int unsigned P8 = 8;

endpackage

// File: rtl/sobel_kernel3x3.sv
// Combinational Sobel Gx/Gy on one 3x3 luma window.
// Ports:
//   win_i   9*PIX_W  window p0..p8, p0 at the LSBs
//   gx_c_o  GRAD_W   signed horizontal gradient
//   gy_c_o  GRAD_W   signed vertical gradient
module sobel_kernel3x3 #(
    parameter int unsigned PIX_W = sobel_mag_sq_pkg::PIX_W
) (
    input  logic [9*PIX_W-1:0]       win_i,
    output logic signed [PIX_W+2:0]  gx_c_o,
    output logic signed [PIX_W+2:0]  gy_c_o
);
    import sobel_mag_sq_pkg::*;

    localparam int unsigned GW = PIX_W + 3;

    logic signed [GW-1:0] pix [9];

    // Zero-extend each pixel into the signed gradient width
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            pix[i] = $signed(GW'(win_i[i*PIX_W +: PIX_W]));
        end
    end

    assign gx_c_o = (pix[P2] + (pix[P5] <<< 1) + pix[P8])
                  - (pix[P0] + (pix[P3] <<< 1) + pix[P6]);
    assign gy_c_o = (pix[P6] + (pix[P7] <<< 1) + pix[P8])
                  - (pix[P0] + (pix[P1] <<< 1) + pix[P2]);

endmodule

// File: rtl/sobel_mag_sq.sv
// Three-stage Sobel squared-magnitude pipe: S1 gradients, S2 squares, S3 sum.
// The whole pipe advances together on en = !out_valid || out_ready.
// Ports:
//   clk, rst_n          pixel clock, async active-low reset
//   in_win/in_last      3x3 window beat and end-of-line marker
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   out_rad/out_last    Gx^2+Gy^2 zero-extended to RAD_W, beat's marker
//   out_valid/out_ready output handshake
module sobel_mag_sq #(
    parameter int unsigned PIX_W = sobel_mag_sq_pkg::PIX_W,
    parameter int unsigned RAD_W = sobel_mag_sq_pkg::RAD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9*PIX_W-1:0]   in_win,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [RAD_W-1:0]     out_rad,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);
    import sobel_mag_sq_pkg::*;

    localparam int unsigned GW    = PIX_W + 3;
    localparam int unsigned ABS_W = PIX_W + 2;
    localparam int unsigned SW    = 2 * (PIX_W + 2);

    // Radicand must hold the full sum of two squares
    if (RAD_W < SW + 1) begin : g_rad_w_check
        $error("sobel_mag_sq: RAD_W too narrow for PIX_W");
    end

    logic en_c;

    logic signed [GW-1:0] gx_c, gy_c;
    logic signed [GW-1:0] gx_q, gy_q;
    logic                 last1_q, v1_q;

    logic [ABS_W-1:0]     ax_c, ay_c;
    logic [SW-1:0]        sqx_d, sqy_d, sqx_q, sqy_q;
    logic                 last2_q, v2_q;

    logic [RAD_W-1:0]     rad_d, rad_q;
    logic                 last3_q, v3_q;

    assign en_c     = !v3_q || out_ready;
    assign in_ready = en_c;

    sobel_kernel3x3 #(.PIX_W(PIX_W)) u_kernel (
        .win_i  (in_win),
        .gx_c_o (gx_c),
        .gy_c_o (gy_c)
    );

    // Magnitudes fit in PIX_W+2 bits since |G| <= 4*(2^PIX_W-1)
    always_comb begin
        ax_c  = gx_q[GW-1] ? ABS_W'(-gx_q) : ABS_W'(gx_q);
        ay_c  = gy_q[GW-1] ? ABS_W'(-gy_q) : ABS_W'(gy_q);
        sqx_d = SW'(ax_c) * SW'(ax_c);
        sqy_d = SW'(ay_c) * SW'(ay_c);
        rad_d = RAD_W'(sqx_q) + RAD_W'(sqy_q);
    end

    // Pipeline registers; bubbles occupy slots and are not squashed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_q    <= '0;
            gy_q    <= '0;
            last1_q <= 1'b0;
            v1_q    <= 1'b0;
            sqx_q   <= '0;
            sqy_q   <= '0;
            last2_q <= 1'b0;
            v2_q    <= 1'b0;
            rad_q   <= '0;
            last3_q <= 1'b0;
            v3_q    <= 1'b0;
        end else if (en_c) begin
            gx_q    <= gx_c;
            gy_q    <= gy_c;
            last1_q <= in_last;
            v1_q    <= in_valid;
            sqx_q   <= sqx_d;
            sqy_q   <= sqy_d;
            last2_q <= last1_q;
            v2_q    <= v1_q;
            rad_q   <= rad_d;
            last3_q <= last2_q;
            v3_q    <= v2_q;
        end
    end

    assign out_rad   = rad_q;
    assign out_last  = last3_q;
    assign out_valid = v3_q;

endmodule
